bsg_tag_tx: RTL and testbench

Serial bsg_tag packet transmitter: the sending end of the tag protocol that the on-chip `bsg_tag_master_decentralized` receives. It accepts parallel tag commands over a valid/ready interface. Each command is serialized LSB-first onto a data/enable pair that is sampled on the same clock as the master's tag clock. It also generates the master-reset bit sequence. It sits in test/bring-up logic (FPGA host bridge or on-chip configuration sequencer) and drives `tag_data_i`/`tag_en_i` of a clock-generator block.

---
 rtl/bsg_tag_tx.sv | 182 ++++++++++++++++++
 tb/tb_bsg_tag_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_tag_tx.sv
// bsg_tag_tx
//   Serial bsg_tag packet transmitter. Accepts parallel tag commands on a
//   valid/ready interface and serializes each one LSB-first onto a
//   data/enable pair clocked by the receiver's tag clock. It also emits the
//   master-reset sequence, which is reset_len_p cycles of data=en=1.
//
//   Frame order (LSB first): start(1), node_id, data_not_reset, len,
//   payload[len-1:0]. Every frame and every reset sequence is followed by
//   gap_p idle cycles.
//
// Ports
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   v_i / ready_and_o       command handshake
//   master_reset_i          send a master-reset sequence; other fields ignored
//   node_id_i               destination client
//   data_not_reset_i        1 = data packet, 0 = client-reset packet
//   len_i, payload_i        payload bit count and payload bits
//   tag_data_o, tag_en_o    registered serial outputs
//   busy_o                  high in every state except IDLE
//
// Build option
//   BSG_TAG_TX_SKID_EN      adds a one-entry command buffer so a command can
//                           be accepted while a frame is in flight.
module bsg_tag_tx #(
    parameter int els_p       = 16,
    parameter int lg_width_p  = 4,
    parameter int gap_p       = 2,
    parameter int reset_len_p = 32,
    localparam int lg_els_p   = $clog2(els_p),
    localparam int max_w      = 2**lg_width_p - 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  v_i,
    output logic                  ready_and_o,
    input  logic                  master_reset_i,
    input  logic [lg_els_p-1:0]   node_id_i,
    input  logic                  data_not_reset_i,
    input  logic [lg_width_p-1:0] len_i,
    input  logic [max_w-1:0]      payload_i,
    output logic                  tag_data_o,
    output logic                  tag_en_o,
    output logic                  busy_o
);

    localparam int hdr_lp  = 2 + lg_els_p + lg_width_p;
    localparam int fmax_lp = hdr_lp + max_w;
    // One counter serves frame bits, reset ones and gap cycles.
    localparam int cmax_lp = (fmax_lp > reset_len_p) ? fmax_lp : reset_len_p;
    localparam int cw_lp   = $clog2(cmax_lp + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, RST, GAP} state_e;

    state_e               state_q, state_d;
    logic [cw_lp-1:0]     cnt_q, cnt_d;
    logic [fmax_lp-1:0]   sh_q, sh_d;
    logic                 data_q, data_d;
    logic                 en_q, en_d;
    logic                 live_q;   // keeps ready low until the first edge after reset

    // Incoming command, already laid out in transmit order.
    logic [fmax_lp-1:0]   in_frame;
    logic [cw_lp-1:0]     in_flen;
    assign in_frame = {payload_i, len_i, data_not_reset_i, node_id_i, 1'b1};
    assign in_flen  = cw_lp'(hdr_lp) + cw_lp'(len_i);

    // Command that starts when go is high in IDLE.
    logic                 sel_mr;
    logic [fmax_lp-1:0]   sel_frame;
    logic [cw_lp-1:0]     sel_flen;
    logic                 go;

`ifdef BSG_TAG_TX_SKID_EN
    logic                 buf_v_q;
    logic                 buf_mr_q;
    logic [fmax_lp-1:0]   buf_frame_q;
    logic [cw_lp-1:0]     buf_flen_q;
    logic                 accept;

    assign ready_and_o = live_q & ~buf_v_q;
    assign accept      = v_i & ready_and_o;
    // A buffered command always goes ahead of anything new (FIFO order);
    // with the buffer empty an IDLE accept starts directly.
    assign sel_mr      = buf_v_q ? buf_mr_q    : master_reset_i;
    assign sel_frame   = buf_v_q ? buf_frame_q : in_frame;
    assign sel_flen    = buf_v_q ? buf_flen_q  : in_flen;
    assign go          = (state_q == IDLE) & (buf_v_q | accept);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            buf_v_q     <= 1'b0;
            buf_mr_q    <= 1'b0;
            buf_frame_q <= '0;
            buf_flen_q  <= '0;
        end else if (accept && state_q != IDLE) begin
            buf_v_q     <= 1'b1;
            buf_mr_q    <= master_reset_i;
            buf_frame_q <= in_frame;
            buf_flen_q  <= in_flen;
        end else if (go && buf_v_q) begin
            buf_v_q     <= 1'b0;
        end
    end
`else
    assign ready_and_o = live_q & (state_q == IDLE);
    assign sel_mr      = master_reset_i;
    assign sel_frame   = in_frame;
    assign sel_flen    = in_flen;
    assign go          = v_i & ready_and_o;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= 1'b0;
            en_q    <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            en_q    <= en_d;
            live_q  <= 1'b1;
        end
    end

    // Outputs are registered from the state, so a bit loaded at edge N is
    // shifted out at edge N+1: one cycle of latency from accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = 1'b0;
        en_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    if (sel_mr) begin
                        state_d = RST;
                        cnt_d   = cw_lp'(reset_len_p);
                    end else begin
                        state_d = SHIFT;
                        sh_d    = sel_frame;
                        cnt_d   = sel_flen;
                    end
                end
            end
            SHIFT: begin
                data_d = sh_q[0];
                en_d   = 1'b1;
                sh_d   = sh_q >> 1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == cw_lp'(1)) begin
                    state_d = GAP;
                    cnt_d   = cw_lp'(gap_p);
                end
            end
            RST: begin
                data_d = 1'b1;
                en_d   = 1'b1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == cw_lp'(1)) begin
                    state_d = GAP;
                    cnt_d   = cw_lp'(gap_p);
                end
            end
            GAP: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == cw_lp'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tag_data_o = data_q;
    assign tag_en_o   = en_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_bsg_tag_tx.sv
// tb_bsg_tag_tx
//   Directed bench for bsg_tag_tx with default parameters (16 nodes,
//   4-bit length, gap 2, reset length 32), plus a random section whose
//   serial stream is decoded back into command fields.
module tb_bsg_tag_tx;

`ifdef BSG_TAG_TX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v = 1'b0;
    logic        mr = 1'b0;
    logic        dnr = 1'b0;
    logic [3:0]  node = '0;
    logic [3:0]  len = '0;
    logic [14:0] pl = '0;
    logic        ready, tdata, ten, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_tag_tx dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .v_i              (v),
        .ready_and_o      (ready),
        .master_reset_i   (mr),
        .node_id_i        (node),
        .data_not_reset_i (dnr),
        .len_i            (len),
        .payload_i        (pl),
        .tag_data_o       (tdata),
        .tag_en_o         (ten),
        .busy_o           (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait (bounded) for ready, and return 1 time unit
    // after the accepting edge with v dropped.
    task automatic send(input logic m, input logic [3:0] n, input logic d,
                        input logic [3:0] l, input logic [14:0] p);
        int t = 0;
        mr = m; node = n; dnr = d; len = l; pl = p; v = 1'b1;
        while (!ready && t < 100) begin
            step();
            t++;
        end
        if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
        step();
        v = 1'b0;
    endtask

    task automatic collect(input int n, output logic [63:0] d, output logic [63:0] e,
                           output int nb);
        d = '0; e = '0; nb = 0;
        for (int i = 0; i < n; i++) begin
            step();
            d[i] = tdata;
            e[i] = ten;
            if (busy) nb++;
        end
    endtask

    initial begin
        logic [63:0] d, e, exp_e, exp_f, got_f, mask;
        logic [3:0]  rn, rl, dl;
        logic [14:0] rp;
        logic        rd, b0;
        int          nb, acc_t, phase;
        logic        rdy_before;

        // ---------------- reset state ----------------
        #12;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_data",  64'(tdata), 64'd0);
        chk("rst_en",    64'(ten),   64'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 64'(ready), 64'd0);
        step();
        chk("ready_after_edge", 64'(ready), 64'd1);

        // ---------------- node 5, dnr 1, len 3, payload 101 ----------------
        send(1'b0, 4'd5, 1'b1, 4'd3, 15'b101);
        chk("t1_busy_accept", 64'(busy), 64'd1);
        collect(13, d, e, nb);
        chk("t1_data", d, 64'h14EB);
        chk("t1_en",   e, 64'h1FFF);
        step();
        chk("t1_gap_out",   64'({tdata, ten}), 64'd0);
        chk("t1_gap_ready", 64'(ready), SKID ? 64'd1 : 64'd0);
        chk("t1_gap_busy",  64'(busy), 64'd1);
        step();
        chk("t1_idle_ready", 64'(ready), 64'd1);
        chk("t1_idle_busy",  64'(busy), 64'd0);
        chk("t1_idle_out",   64'({tdata, ten}), 64'd0);

        // ---------------- header-only frame, junk payload ignored ----------------
        send(1'b0, 4'd15, 1'b0, 4'd0, 15'h7FFF);
        collect(10, d, e, nb);
        chk("t2_data", d, 64'h01F);
        chk("t2_en",   e, 64'h3FF);
        collect(3, d, e, nb);
        chk("t2_tail", d | e, 64'd0);

        // ---------------- master reset ----------------
        send(1'b1, 4'd3, 1'b1, 4'd7, 15'h1234);
        b0 = busy;
        collect(40, d, e, nb);
        chk("t3_data", d, 64'hFFFF_FFFF);
        chk("t3_en",   e, 64'hFFFF_FFFF);
        chk("t3_busy_cycles", 64'(nb + int'(b0)), 64'd34);

        // ---------------- back-to-back with v held ----------------
        mr = 1'b0; node = 4'd5; dnr = 1'b1; len = 4'd3; pl = 15'b101; v = 1'b1;
        d = '0; e = '0; acc_t = -1; phase = 0;
        for (int t = 0; t < 40; t++) begin
            rdy_before = ready;
            step();
            if (v && rdy_before) begin
                if (phase == 0) begin
                    phase = 1;
                    node = 4'd15; dnr = 1'b0; len = 4'd0; pl = 15'd0;
                end else begin
                    acc_t = t;
                    v = 1'b0;
                end
            end
            d[t] = tdata;
            e[t] = ten;
        end
        v = 1'b0;
        chk("t4_second_accept", 64'(acc_t), SKID ? 64'd1 : 64'd16);
        chk("t4_data", d, (64'h14EB << 1) | (64'h01F << 17));
        chk("t4_en",   e, (64'h1FFF << 1) | (64'h3FF << 17));

        // ---------------- reset during frame bit 6 ----------------
        send(1'b0, 4'd5, 1'b1, 4'd3, 15'b101);
        collect(6, d, e, nb);
        chk("t5_prefix", d, 64'h2B);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_data",  64'(tdata), 64'd0);
        chk("t5_async_en",    64'(ten),   64'd0);
        chk("t5_async_busy",  64'(busy),  64'd0);
        chk("t5_async_ready", 64'(ready), 64'd0);
        #3;
        rst_n = 1'b1;
        step();
        chk("t5_ready_release", 64'(ready), 64'd1);
        send(1'b1, 4'd0, 1'b0, 4'd0, 15'd0);
        collect(34, d, e, nb);
        chk("t5_mr_en", e, 64'hFFFF_FFFF);
        send(1'b0, 4'd5, 1'b1, 4'd3, 15'b101);
        collect(13, d, e, nb);
        chk("t5_after_data", d, 64'h14EB);
        chk("t5_after_en",   e, 64'h1FFF);

        // ---------------- random commands, decoded from the stream ----------------
        for (int k = 0; k < 200; k++) begin
            rn = 4'($urandom_range(0, 15));
            rl = 4'($urandom_range(0, 15));
            rd = 1'($urandom_range(0, 1));
            rp = 15'($urandom);
            send(1'b0, rn, rd, rl, rp);
            collect(27, d, e, nb);
            dl    = d[9:6];
            mask  = (64'd1 << dl) - 64'd1;
            got_f = {41'd0, d[0], d[4:1], d[5], dl, 15'((d >> 10) & mask)};
            exp_f = {41'd0, 1'b1, rn, rd, rl, 15'(64'(rp) & ((64'd1 << rl) - 64'd1))};
            exp_e = (64'd1 << (10 + int'(rl))) - 64'd1;
            chk("rnd_fields", got_f, exp_f);
            chk("rnd_en", e, exp_e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
